// File: rtl/accel_layer_sequencer_if.sv
// Configuration/status bus between the layer sequencer (master) and the accelerator core (slave).
interface accel_layer_sequencer_if #(
    parameter int REG_WIDTH = 32
);
    logic [REG_WIDTH-1:0] conf_ctrl;
    logic [REG_WIDTH-1:0] conf_outputsize;
    logic [REG_WIDTH-1:0] conf_kernelsize;
    logic [REG_WIDTH-1:0] conf_weightinterval;
    logic [REG_WIDTH-1:0] conf_kernelshape;
    logic [REG_WIDTH-1:0] conf_inputshape;
    logic [REG_WIDTH-1:0] conf_inputrstcnt;
    logic [REG_WIDTH-1:0] conf_status;

    modport master (
        output conf_ctrl, conf_outputsize, conf_kernelsize, conf_weightinterval,
               conf_kernelshape, conf_inputshape, conf_inputrstcnt,
        input  conf_status
    );

    modport slave (
        input  conf_ctrl, conf_outputsize, conf_kernelsize, conf_weightinterval,
               conf_kernelshape, conf_inputshape, conf_inputrstcnt,
        output conf_status
    );
endinterface

// File: rtl/accel_layer_sequencer.sv
// Walks the accelerator core through a list of layer/tile descriptors:
// load config, soft reset, start, wait for both done bits, with watchdog and abort.
module accel_layer_sequencer #(
    parameter int REG_WIDTH    = 32,
    parameter int NUM_DESC     = 8,
    parameter int DESC_AW      = 3,
    parameter int SRST_CYCLES  = 2,
    parameter int STATUS_GUARD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_desc_wr,
    input  logic [DESC_AW-1:0]   i_desc_idx,
    input  logic [2:0]           i_desc_word,
    input  logic [REG_WIDTH-1:0] i_desc_data,
    input  logic [DESC_AW:0]     i_num_desc,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [REG_WIDTH-1:0] i_timeout_limit,
    accel_layer_sequencer_if.master core_if,
    output logic [DESC_AW-1:0]   o_cur_desc,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err_timeout,
    output logic                 o_err_abort
);
    localparam int NUM_WORDS = 6;
    localparam logic [REG_WIDTH-1:0] CTRL_START = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] CTRL_SRST  = REG_WIDTH'(2);
    localparam logic [7:0]           PHASE_LAST = 8'(SRST_CYCLES - 1);
    localparam logic [DESC_AW:0]     CNT_ONE    = (DESC_AW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SRST, S_RUN, S_NEXT, S_ABORT} state_t;

    logic [NUM_WORDS-1:0][REG_WIDTH-1:0] r_desc [NUM_DESC];

    state_t                              r_state;
    logic [REG_WIDTH-1:0]                r_ctrl;
    logic [NUM_WORDS-1:0][REG_WIDTH-1:0] r_conf;
    logic [DESC_AW-1:0]                  r_cur_desc;
    logic [DESC_AW:0]                    r_count;
    logic [REG_WIDTH-1:0]                r_run_cnt;
    logic [7:0]                          r_phase_cnt;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_err_timeout;
    logic                                r_err_abort;

    logic [REG_WIDTH-1:0] w_run_next;
    logic [DESC_AW:0]     w_cur_inc;
    logic                 w_status_done;
    logic                 w_guard_over;
    logic                 w_timeout;
    logic                 w_start_ok;
    logic                 w_unused_status;

    assign w_run_next    = (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + REG_WIDTH'(1);
    assign w_cur_inc     = {1'b0, r_cur_desc} + CNT_ONE;
    assign w_status_done = (core_if.conf_status[1:0] == 2'b11);
    assign w_guard_over  = (r_run_cnt >= REG_WIDTH'(STATUS_GUARD));
    assign w_timeout     = (i_timeout_limit != '0) && (w_run_next >= i_timeout_limit);
    assign w_start_ok    = (i_num_desc != '0) && (i_num_desc <= (DESC_AW+1)'(NUM_DESC));
    assign w_unused_status = ^core_if.conf_status[REG_WIDTH-1:2];

    // Word selects 6 and 7 have no backing storage and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DESC; i++) begin
                r_desc[i] <= '0;
            end
        end else if (i_desc_wr && (i_desc_word < 3'(NUM_WORDS))) begin
            r_desc[i_desc_idx][i_desc_word] <= i_desc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ctrl        <= '0;
            r_conf        <= '0;
            r_cur_desc    <= '0;
            r_count       <= '0;
            r_run_cnt     <= '0;
            r_phase_cnt   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_abort   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Abort outranks everything, including completion in NEXT.
            if (i_abort && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
                r_err_abort <= 1'b1;
                r_ctrl      <= CTRL_SRST;
                r_phase_cnt <= '0;
                r_state     <= S_ABORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (w_start_ok) begin
                                r_count       <= i_num_desc;
                                r_cur_desc    <= '0;
                                r_err_timeout <= 1'b0;
                                r_err_abort   <= 1'b0;
                                r_busy        <= 1'b1;
                                r_state       <= S_LOAD;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_conf      <= r_desc[r_cur_desc];
                        r_ctrl      <= CTRL_SRST;
                        r_phase_cnt <= '0;
                        r_state     <= S_SRST;
                    end
                    S_SRST: begin
                        if (r_phase_cnt == PHASE_LAST) begin
                            r_ctrl    <= CTRL_START;
                            r_run_cnt <= '0;
                            r_state   <= S_RUN;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + 8'd1;
                        end
                    end
                    S_RUN: begin
                        // Done is tested first so it wins over a same-cycle timeout.
                        if (w_guard_over && w_status_done) begin
                            r_ctrl  <= '0;
                            r_state <= S_NEXT;
                        end else if (w_timeout) begin
                            r_err_timeout <= 1'b1;
                            r_ctrl        <= CTRL_SRST;
                            r_phase_cnt   <= '0;
                            r_state       <= S_ABORT;
                        end else begin
                            r_run_cnt <= w_run_next;
                        end
                    end
                    S_NEXT: begin
                        if (w_cur_inc == r_count) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cur_desc <= w_cur_inc[DESC_AW-1:0];
                            r_state    <= S_LOAD;
                        end
                    end
                    S_ABORT: begin
                        if (r_phase_cnt == PHASE_LAST) begin
                            r_ctrl  <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_ctrl  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign core_if.conf_ctrl           = r_ctrl;
    assign core_if.conf_outputsize     = r_conf[0];
    assign core_if.conf_kernelsize     = r_conf[1];
    assign core_if.conf_weightinterval = r_conf[2];
    assign core_if.conf_kernelshape    = r_conf[3];
    assign core_if.conf_inputshape     = r_conf[4];
    assign core_if.conf_inputrstcnt    = r_conf[5];

    assign o_cur_desc    = r_cur_desc;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err_timeout = r_err_timeout;
    assign o_err_abort   = r_err_abort;
endmodule

// File: tb/tb_accel_layer_sequencer.sv
// Self-checking bench: table of whole-run vectors, cycle traces from a run-level model, and hand sequences.
module tb_accel_layer_sequencer;
    localparam int RW    = 32;
    localparam int ND    = 8;
    localparam int AW    = 3;
    localparam int SRST  = 2;
    localparam int GUARD = 2;
    localparam int NEVER = 1 << 20;

    typedef struct {
        logic [RW-1:0] ctrl;
        int            cur;
        bit            busy;
        bit            done;
        bit            errt;
        bit            load;
        bit            chk_conf;
    } exp_t;

    typedef struct {
        int n;
        int delay;
        int limit;
        int exp_busy;
        int exp_active;
        int exp_done;
        int exp_errt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_desc_wr;
    logic [AW-1:0] i_desc_idx;
    logic [2:0]    i_desc_word;
    logic [RW-1:0] i_desc_data;
    logic [AW:0]   i_num_desc;
    logic          i_start;
    logic          i_abort;
    logic [RW-1:0] i_timeout_limit;
    logic [AW-1:0] o_cur_desc;
    logic          o_busy;
    logic          o_done;
    logic          o_err_timeout;
    logic          o_err_abort;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] model_mem [ND][6];
    logic [RW-1:0] snap [6];
    int delay_q [ND];
    int run_j = 0;
    vec_t vecs [11];

    always #5 clk = ~clk;

    accel_layer_sequencer_if #(.REG_WIDTH(RW)) core_if ();

    accel_layer_sequencer #(
        .REG_WIDTH(RW), .NUM_DESC(ND), .DESC_AW(AW),
        .SRST_CYCLES(SRST), .STATUS_GUARD(GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_desc_wr(i_desc_wr),
        .i_desc_idx(i_desc_idx),
        .i_desc_word(i_desc_word),
        .i_desc_data(i_desc_data),
        .i_num_desc(i_num_desc),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_timeout_limit(i_timeout_limit),
        .core_if(core_if),
        .o_cur_desc(o_cur_desc),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err_timeout(o_err_timeout),
        .o_err_abort(o_err_abort)
    );

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] get_conf(input int w);
        case (w)
            0:       return core_if.conf_outputsize;
            1:       return core_if.conf_kernelsize;
            2:       return core_if.conf_weightinterval;
            3:       return core_if.conf_kernelshape;
            4:       return core_if.conf_inputshape;
            default: return core_if.conf_inputrstcnt;
        endcase
    endfunction

    function automatic exp_t mk(input int ctrl, input int cur, input bit busy, input bit done,
                                input bit errt, input bit load, input bit chk);
        exp_t e;
        e.ctrl = RW'(ctrl); e.cur = cur; e.busy = busy; e.done = done;
        e.errt = errt; e.load = load; e.chk_conf = chk;
        return e;
    endfunction

    // Behavioural core: raises both done bits from RUN cycle delay_q[desc] onward, noise otherwise.
    task automatic respond();
        logic [31:0] noise;
        noise = $urandom();
        if (core_if.conf_ctrl == RW'(1)) begin
            if (run_j >= delay_q[o_cur_desc])
                core_if.conf_status = {noise[31:2], 2'b11};
            else
                core_if.conf_status = {noise[31:2], (noise[1:0] == 2'b11) ? 2'b01 : noise[1:0]};
            run_j++;
        end else begin
            run_j = 0;
            core_if.conf_status = noise;
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < ND; i++) delay_q[i] = d;
    endtask

    task automatic wr(input int idx, input int word, input logic [RW-1:0] data);
        i_desc_wr = 1'b1; i_desc_idx = AW'(idx); i_desc_word = 3'(word); i_desc_data = data;
        if (word < 6) model_mem[idx][word] = data;
        respond(); step();
        i_desc_wr = 1'b0;
    endtask

    task automatic kick(input int n, input int limit);
        i_num_desc = (AW+1)'(n); i_timeout_limit = RW'(limit); i_start = 1'b1;
        respond(); step();
        i_start = 1'b0;
    endtask

    // Expected cycle trace derived from run-level rules: per descriptor LOAD, SRST window,
    // RUN length max(delay,GUARD)+1 unless the watchdog fires first, then NEXT or ABORT.
    task automatic run_traced(input int n, input int limit, input bit disturb);
        exp_t tr[$];
        int   last;
        bit   errt;
        last = 0; errt = 0;
        for (int k = 0; k < n; k++) begin
            int dd, rcyc;
            bit to;
            dd   = (delay_q[k] > GUARD) ? delay_q[k] : GUARD;
            to   = (limit != 0) && (limit - 1 < dd);
            rcyc = to ? limit : dd + 1;
            last = k;
            tr.push_back(mk(0, k, 1, 0, 0, 1, k > 0));
            repeat (SRST) tr.push_back(mk(2, k, 1, 0, 0, 0, 1));
            repeat (rcyc) tr.push_back(mk(1, k, 1, 0, 0, 0, 1));
            if (to) begin
                repeat (SRST) tr.push_back(mk(2, k, 1, 0, 1, 0, 1));
                errt = 1;
                break;
            end
            tr.push_back(mk(0, k, 1, 0, 0, 0, 1));
            if (k == n - 1) tr.push_back(mk(0, k, 0, 1, 0, 0, 1));
        end
        repeat (2) tr.push_back(mk(0, last, 0, 0, errt, 0, 1));

        kick(n, limit);
        for (int c = 0; c < tr.size(); c++) begin
            check($sformatf("c%0d ctrl", c), core_if.conf_ctrl, tr[c].ctrl);
            check($sformatf("c%0d cur", c), RW'(o_cur_desc), RW'(tr[c].cur));
            check($sformatf("c%0d busy", c), RW'(o_busy), RW'(tr[c].busy));
            check($sformatf("c%0d done", c), RW'(o_done), RW'(tr[c].done));
            check($sformatf("c%0d err_timeout", c), RW'(o_err_timeout), RW'(tr[c].errt));
            check($sformatf("c%0d err_abort", c), RW'(o_err_abort), RW'(0));
            if (tr[c].chk_conf)
                for (int w = 0; w < 6; w++)
                    check($sformatf("c%0d conf%0d", c, w), get_conf(w), snap[w]);
            if (tr[c].load)
                for (int w = 0; w < 6; w++) snap[w] = model_mem[tr[c].cur][w];
            i_start = 1'b0; i_desc_wr = 1'b0;
            if (disturb && tr[c].busy && $urandom_range(0, 7) == 0) begin
                i_start = 1'b1;
                i_num_desc = (AW+1)'($urandom_range(0, 15));
            end
            if (disturb && $urandom_range(0, 3) == 0) begin
                int wi, ww;
                wi = $urandom_range(0, ND - 1);
                ww = $urandom_range(0, 7);
                i_desc_wr = 1'b1; i_desc_idx = AW'(wi); i_desc_word = 3'(ww);
                i_desc_data = $urandom();
                if (ww < 6) model_mem[wi][ww] = i_desc_data;
            end
            respond(); step();
        end
        i_start = 1'b0; i_desc_wr = 1'b0;
        $display("traced run n=%0d limit=%0d cycles=%0d", n, limit, tr.size());
    endtask

    task automatic run_vector(input vec_t v);
        int busy_c, act_c, done_c, idle_c;
        busy_c = 0; act_c = 0; done_c = 0; idle_c = 0;
        set_delays(v.delay);
        kick(v.n, v.limit);
        for (int c = 0; c < 3000 && idle_c < 3; c++) begin
            if (o_busy) busy_c++; else idle_c++;
            if (core_if.conf_ctrl != '0) act_c++;
            if (o_done) done_c++;
            respond(); step();
        end
        check("vec bound", RW'(idle_c >= 3), RW'(1));
        check("vec busy cycles", RW'(busy_c), RW'(v.exp_busy));
        check("vec ctrl cycles", RW'(act_c), RW'(v.exp_active));
        check("vec done pulses", RW'(done_c), RW'(v.exp_done));
        check("vec err_timeout", RW'(o_err_timeout), RW'(v.exp_errt));
        $display("vector n=%0d delay=%0d limit=%0d busy=%0d ctrl=%0d done=%0d",
                 v.n, v.delay, v.limit, busy_c, act_c, done_c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"}, core_if.conf_ctrl, '0);
        for (int w = 0; w < 6; w++) check($sformatf("%s conf%0d", tag, w), get_conf(w), '0);
        check({tag, " cur"}, RW'(o_cur_desc), '0);
        check({tag, " busy"}, RW'(o_busy), '0);
        check({tag, " done"}, RW'(o_done), '0);
        check({tag, " err_timeout"}, RW'(o_err_timeout), '0);
        check({tag, " err_abort"}, RW'(o_err_abort), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        vecs[0]  = '{1, 10, 0, 15, 13, 1, 0};
        vecs[1]  = '{3, 0, 0, 21, 15, 1, 0};
        vecs[2]  = '{1, 0, 0, 7, 5, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 1, 0};
        vecs[4]  = '{9, 0, 0, 0, 0, 1, 0};
        vecs[5]  = '{2, 5, 50, 20, 16, 1, 0};
        vecs[6]  = '{1, NEVER, 50, 55, 54, 0, 1};
        vecs[7]  = '{2, 4, 5, 18, 14, 1, 0};
        vecs[8]  = '{1, 5, 5, 10, 9, 0, 1};
        vecs[9]  = '{8, 2, 0, 56, 40, 1, 0};
        vecs[10] = '{1, NEVER, 1, 6, 5, 0, 1};

        rst = 1'b1; i_desc_wr = 1'b0; i_desc_idx = '0; i_desc_word = '0; i_desc_data = '0;
        i_num_desc = '0; i_start = 1'b0; i_abort = 1'b0; i_timeout_limit = '0;
        core_if.conf_status = '0;
        for (int i = 0; i < ND; i++) for (int w = 0; w < 6; w++) model_mem[i][w] = '0;
        for (int w = 0; w < 6; w++) snap[w] = '0;
        set_delays(0);
        repeat (3) step();
        rst = 1'b0;
        step();
        check_all_zero("reset");

        for (int w = 0; w < 6; w++) wr(0, w, RW'(32'h10 + w));
        for (int i = 1; i < ND; i++)
            for (int w = 0; w < 6; w++) wr(i, w, RW'(32'h100 * i + 32'h10 * w + 7));
        wr(2, 6, 32'hdead_beef);
        wr(3, 7, 32'hcafe_f00d);

        set_delays(10);
        run_traced(1, 0, 0);
        delay_q[0] = 2; delay_q[1] = 5; delay_q[2] = 0;
        run_traced(3, 0, 0);
        set_delays(0);
        run_traced(1, 0, 0);

        for (int v = 0; v < 11; v++) run_vector(vecs[v]);

        // Abort during RUN of descriptor 1, then abort in IDLE, then a clean restart.
        set_delays(3); delay_q[1] = NEVER;
        kick(3, 0);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (o_cur_desc == AW'(1) && core_if.conf_ctrl == RW'(1)) cnt++;
            if (cnt == 4) break;
            respond(); step();
        end
        check("abort reach run1", RW'(cnt), RW'(4));
        i_abort = 1'b1; respond(); step(); i_abort = 1'b0;
        check("abort c1 ctrl", core_if.conf_ctrl, RW'(2));
        check("abort c1 err_abort", RW'(o_err_abort), RW'(1));
        check("abort c1 busy", RW'(o_busy), RW'(1));
        respond(); step();
        check("abort c2 ctrl", core_if.conf_ctrl, RW'(2));
        check("abort c2 done", RW'(o_done), RW'(0));
        respond(); step();
        check("abort c3 ctrl", core_if.conf_ctrl, RW'(0));
        check("abort c3 busy", RW'(o_busy), RW'(0));
        check("abort c3 done", RW'(o_done), RW'(0));
        check("abort c3 err_abort", RW'(o_err_abort), RW'(1));
        i_abort = 1'b1; respond(); step(); i_abort = 1'b0;
        check("idle abort busy", RW'(o_busy), RW'(0));
        check("idle abort ctrl", core_if.conf_ctrl, RW'(0));
        check("idle abort err_abort", RW'(o_err_abort), RW'(1));
        set_delays(0);
        run_traced(3, 0, 0);

        // Abort in the same NEXT cycle as the final completion: abort wins, no done.
        kick(1, 0);
        repeat (6) begin respond(); step(); end
        check("next-abort ctrl", core_if.conf_ctrl, RW'(0));
        check("next-abort busy", RW'(o_busy), RW'(1));
        i_abort = 1'b1; respond(); step(); i_abort = 1'b0;
        check("next-abort c1 ctrl", core_if.conf_ctrl, RW'(2));
        check("next-abort c1 done", RW'(o_done), RW'(0));
        check("next-abort c1 err_abort", RW'(o_err_abort), RW'(1));
        respond(); step();
        check("next-abort c2 ctrl", core_if.conf_ctrl, RW'(2));
        check("next-abort c2 done", RW'(o_done), RW'(0));
        respond(); step();
        check("next-abort c3 ctrl", core_if.conf_ctrl, RW'(0));
        check("next-abort c3 busy", RW'(o_busy), RW'(0));
        check("next-abort c3 done", RW'(o_done), RW'(0));
        $display("abort sequences done");

        for (int r = 0; r < 12; r++) begin
            int n, limit;
            n = $urandom_range(1, ND);
            limit = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            for (int i = 0; i < ND; i++) begin
                delay_q[i] = $urandom_range(0, 8);
                if (limit != 0 && $urandom_range(0, 7) == 0) delay_q[i] = NEVER;
            end
            run_traced(n, limit, 1);
        end

        // Reset mid-sequence clears outputs and descriptor storage.
        set_delays(NEVER);
        kick(2, 0);
        repeat (5) begin respond(); step(); end
        rst = 1'b1; respond(); step(); rst = 1'b0;
        check_all_zero("midrst");
        for (int i = 0; i < ND; i++) for (int w = 0; w < 6; w++) model_mem[i][w] = '0;
        for (int w = 0; w < 6; w++) snap[w] = '0;
        set_delays(1);
        run_traced(2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
